// File: rtl/mem_arbiter_2m_pkg.sv
// Shared types and constants for the two-master PicoRV32-native memory arbiter.
package mem_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_e;

   localparam logic [31:0] ERR_RDATA_DEF = 32'hDEADBEEF;
   // Upper 12 address bits that select the LED MMIO decoder behind the slave.
   localparam logic [11:0] MMIO_BASE = 12'hFF2;

endpackage

// File: rtl/mem_arbiter_2m_if.sv
// PicoRV32-native memory bus. valid/ready: the requester raises valid with stable fields and holds
// them until the responder returns a single-cycle ready pulse; rdata is meaningful only during that pulse.
interface mem_arbiter_2m_if;
   logic        valid;
   logic        instr;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        ready;
   logic [31:0] rdata;

   modport master (output valid, instr, addr, wdata, wstrb, input ready, rdata);
   modport slave  (input valid, instr, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/mem_arbiter_2m_rr_pick.sv
// Two-way round-robin picker: a lone requester wins, on contention the one not served last wins.
module mem_arb_rr_pick (
   input  logic [1:0] valid,
   input  logic       last_grant,
   output logic       grant,
   output logic       any
);

   assign any = |valid;

   always_comb begin
      grant = 1'b0;
      case (valid)
         2'b01:   grant = 1'b0;
         2'b10:   grant = 1'b1;
         2'b11:   grant = ~last_grant;
         default: grant = 1'b0;
      endcase
   end

endmodule

// File: rtl/mem_arbiter_2m.sv
// Shares one memory slave between two masters, one transaction in flight, with a stall timeout
// that completes the master with ERR_RDATA and records the failing address.
module mem_arbiter_2m
   import mem_arb_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned TIMEOUT_W      = 8,
   parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEF
) (
   input  logic                    clk,
   input  logic                    resetn,
   mem_arbiter_2m_if.slave         m0,
   mem_arbiter_2m_if.slave         m1,
   mem_arbiter_2m_if.master        mem,
   output logic                    err_flag,
   output logic [31:0]             err_addr,
   output state_e                  dbg_state
);

   localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

   state_e                state_q, state_d;
   logic                  mem_valid_q, mem_valid_d;
   logic                  grant_q, grant_d;
   logic                  last_grant_q, last_grant_d;
   logic [TIMEOUT_W-1:0]  cnt_q, cnt_d;
   logic                  err_flag_q, err_flag_d;
   logic [31:0]           err_addr_q, err_addr_d;
   logic                  pick_grant, pick_any;
   logic                  done_ok, done_to, done;
   logic [31:0]           rdata_sel;

   mem_arb_rr_pick u_pick (
      .valid      ({m1.valid, m0.valid}),
      .last_grant (last_grant_q),
      .grant      (pick_grant),
      .any        (pick_any)
   );

   always_comb begin
      state_d      = state_q;
      mem_valid_d  = mem_valid_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      cnt_d        = cnt_q;
      err_flag_d   = err_flag_q;
      err_addr_d   = err_addr_q;
      done_ok      = 1'b0;
      done_to      = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick_any) begin
               grant_d     = pick_grant;
               mem_valid_d = 1'b1;
               cnt_d       = '0;
               state_d     = BUSY;
            end
         end
         BUSY: begin
            // A real response in the last timeout cycle still counts as a normal completion.
            if (mem.ready) begin
               done_ok      = 1'b1;
               mem_valid_d  = 1'b0;
               last_grant_d = grant_q;
               state_d      = IDLE;
            end else if (cnt_q == CNT_LAST) begin
               done_to      = 1'b1;
               err_flag_d   = 1'b1;
               err_addr_d   = mem.addr;
               mem_valid_d  = 1'b0;
               last_grant_d = grant_q;
               state_d      = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q      <= IDLE;
         mem_valid_q  <= 1'b0;
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;
         cnt_q        <= '0;
         err_flag_q   <= 1'b0;
         err_addr_q   <= '0;
      end else begin
         state_q      <= state_d;
         mem_valid_q  <= mem_valid_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         cnt_q        <= cnt_d;
         err_flag_q   <= err_flag_d;
         err_addr_q   <= err_addr_d;
      end
   end

   assign mem.valid = mem_valid_q;
   assign mem.instr = grant_q ? m1.instr : m0.instr;
   assign mem.addr  = grant_q ? m1.addr  : m0.addr;
   assign mem.wdata = grant_q ? m1.wdata : m0.wdata;
   // Strobes are masked while idle so a stale grant can never look like a write.
   assign mem.wstrb = (state_q == BUSY) ? (grant_q ? m1.wstrb : m0.wstrb) : 4'b0000;

   assign done      = resetn && (done_ok || done_to);
   assign rdata_sel = done_ok ? mem.rdata : ERR_RDATA;
   assign m0.ready  = done && !grant_q;
   assign m1.ready  = done && grant_q;
   assign m0.rdata  = m0.ready ? rdata_sel : 32'h0;
   assign m1.rdata  = m1.ready ? rdata_sel : 32'h0;

   assign err_flag  = err_flag_q;
   assign err_addr  = err_addr_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_arbiter_2m.sv
// Directed bench for mem_arbiter_2m: single reads/writes, contention fairness, timeout and reset abort.
module tb_mem_arbiter_2m;
  import mem_arb_pkg::*;

  localparam int TO = 8;
  localparam logic [31:0] RD_XOR = 32'h5A5A_0000;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_2m_if m0_if ();
  mem_arbiter_2m_if m1_if ();
  mem_arbiter_2m_if mem_if ();

  logic        err_flag;
  logic [31:0] err_addr;
  state_e      dbg_state;

  mem_arbiter_2m #(
    .TIMEOUT_CYCLES (TO),
    .TIMEOUT_W      (8),
    .ERR_RDATA      (32'hDEADBEEF)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .m0        (m0_if),
    .m1        (m1_if),
    .mem       (mem_if),
    .err_flag  (err_flag),
    .err_addr  (err_addr),
    .dbg_state (dbg_state)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int m0_pulses = 0;
  int m1_pulses = 0;
  int gap_viol = 0;
  logic prev_done = 1'b0;
  int slave_lat = 1;
  int lat = 0;
  logic use_fixed = 1'b0;
  logic [31:0] slave_rdata = 32'h0;
  logic [32:0] exp_q[$];

  // ---------------- clock / reset / monitors ----------------
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (m0_if.ready) m0_pulses++;
    if (m1_if.ready) m1_pulses++;
    if (prev_done && mem_if.valid) gap_viol++;
    prev_done = mem_if.valid && (m0_if.ready || m1_if.ready);
  end

  // Slave model: ready arrives slave_lat cycles after valid is first seen; 0 means never.
  initial begin
    mem_if.ready = 1'b0;
    mem_if.rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (!mem_if.valid || mem_if.ready) begin
        mem_if.ready = 1'b0;
        mem_if.rdata = 32'h0;
        lat = 0;
      end else begin
        lat++;
        if (slave_lat != 0 && lat == slave_lat + 1) begin
          mem_if.ready = 1'b1;
          mem_if.rdata = use_fixed ? slave_rdata : (mem_if.addr ^ RD_XOR);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m(input int m, input logic v, input logic ins, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] ws);
    if (m == 0) begin
      m0_if.valid = v; m0_if.instr = ins; m0_if.addr = a; m0_if.wdata = wd; m0_if.wstrb = ws;
    end else begin
      m1_if.valid = v; m1_if.instr = ins; m1_if.addr = a; m1_if.wdata = wd; m1_if.wstrb = ws;
    end
  endtask

  task automatic idle_masters();
    drive_m(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive_m(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic do_reset();
    tick();
    resetn = 1'b0;
    idle_masters();
    repeat (2) tick();
    resetn = 1'b1;
  endtask

  task automatic wait_ready(input int max, output int who, output logic [31:0] rd);
    who = -1;
    rd = 32'h0;
    for (int i = 0; i < max && who < 0; i++) begin
      @(negedge clk);
      if (m0_if.ready) begin who = 0; rd = m0_if.rdata; end
      else if (m1_if.ready) begin who = 1; rd = m1_if.rdata; end
    end
  endtask

  // ---------------- tests ----------------
  initial begin
    int who;
    int t0;
    int p0, p1, n0, n1;
    logic [31:0] rd;

    idle_masters();
    repeat (3) tick();
    @(negedge clk);
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    check("rst_mem_valid", 64'(mem_if.valid), 64'd0);
    check("rst_err_flag", 64'(err_flag), 64'd0);
    check("rst_err_addr", 64'(err_addr), 64'd0);
    tick();
    resetn = 1'b1;

    // 1: lone M0 read, 1-cycle slave
    tick();
    use_fixed = 1'b1; slave_rdata = 32'h1234_5678; slave_lat = 1;
    drive_m(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'h0);
    t0 = cyc;
    @(negedge clk);
    check("t1_idle_mem_valid", 64'(mem_if.valid), 64'd0);
    wait_ready(20, who, rd);
    check("t1_who", 64'(who), 64'd0);
    check("t1_latency", 64'(cyc - t0), 64'd2);
    check("t1_rdata", 64'(rd), 64'h1234_5678);
    check("t1_m1_ready", 64'(m1_if.ready), 64'd0);
    check("t1_m1_rdata", 64'(m1_if.rdata), 64'd0);
    tick();
    idle_masters();
    tick();
    @(negedge clk);
    check("t1_m0_pulses", 64'(m0_pulses), 64'd1);
    check("t1_after_rdata", 64'(m0_if.rdata), 64'd0);

    // 2: continuous contention from reset, strict alternation
    do_reset();
    use_fixed = 1'b0; slave_lat = 1; gap_viol = 0;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back({1'b0, (32'h100 + 32'(4 * k)) ^ RD_XOR});
      exp_q.push_back({1'b1, (32'h200 + 32'(4 * k)) ^ RD_XOR});
    end
    tick();
    drive_m(0, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
    drive_m(1, 1'b1, 1'b0, 32'h200, 32'h0, 4'h0);
    n0 = 0; n1 = 0;
    for (int k = 0; k < 8; k++) begin
      wait_ready(40, who, rd);
      check("t2_txn", 64'({who[0], rd}), 64'(exp_q.pop_front()));
      tick();
      if (who == 0) begin
        n0++;
        if (n0 == 4) m0_if.valid = 1'b0; else m0_if.addr = 32'h100 + 32'(4 * n0);
      end else if (who == 1) begin
        n1++;
        if (n1 == 4) m1_if.valid = 1'b0; else m1_if.addr = 32'h200 + 32'(4 * n1);
      end
    end
    idle_masters();
    check("t2_gap_viol", 64'(gap_viol), 64'd0);
    check("t2_queue_left", 64'(exp_q.size()), 64'd0);

    // 3: M1 partial write, then M0 instruction fetch from the MMIO window
    tick();
    p1 = m1_pulses;
    drive_m(1, 1'b1, 1'b0, 32'h0000_0020, 32'hAABB_CCDD, 4'b0011);
    @(negedge clk);
    check("t3_idle_wstrb", 64'(mem_if.wstrb), 64'd0);
    @(negedge clk);
    check("t3_mem_valid", 64'(mem_if.valid), 64'd1);
    check("t3_mem_addr", 64'(mem_if.addr), 64'h20);
    check("t3_mem_wdata", 64'(mem_if.wdata), 64'hAABB_CCDD);
    check("t3_mem_wstrb", 64'(mem_if.wstrb), 64'h3);
    wait_ready(20, who, rd);
    check("t3_who", 64'(who), 64'd1);
    tick();
    idle_masters();
    drive_m(0, 1'b1, 1'b1, {MMIO_BASE, 20'h4}, 32'h0, 4'h0);
    @(negedge clk);
    @(negedge clk);
    check("t3_pulse_count", 64'(m1_pulses - p1), 64'd1);
    check("t3b_instr", 64'(mem_if.instr), 64'd1);
    check("t3b_addr", 64'(mem_if.addr), 64'hFF20_0004);
    wait_ready(20, who, rd);
    check("t3b_rdata", 64'(rd), 64'hFF20_0004 ^ 64'(RD_XOR));
    tick();
    idle_masters();

    // 4: slave never responds -> forced completion with error data
    slave_lat = 0;
    tick();
    drive_m(0, 1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'h0);
    t0 = cyc;
    wait_ready(30, who, rd);
    check("t4_who", 64'(who), 64'd0);
    check("t4_latency", 64'(cyc - t0), 64'(TO));
    check("t4_rdata", 64'(rd), 64'hDEAD_BEEF);
    check("t4_err_before", 64'(err_flag), 64'd0);
    tick();
    idle_masters();
    @(negedge clk);
    check("t4_err_flag", 64'(err_flag), 64'd1);
    check("t4_err_addr", 64'(err_addr), 64'h40);
    check("t4_mem_valid", 64'(mem_if.valid), 64'd0);
    tick();
    check("t4_err_sticky", 64'(err_flag), 64'd1);

    // 5: response lands exactly in the timeout cycle
    do_reset();
    use_fixed = 1'b1; slave_rdata = 32'hCAFE_F00D; slave_lat = TO - 1;
    tick();
    drive_m(1, 1'b1, 1'b0, 32'h0000_0044, 32'h0, 4'h0);
    t0 = cyc;
    wait_ready(30, who, rd);
    check("t5_who", 64'(who), 64'd1);
    check("t5_latency", 64'(cyc - t0), 64'(TO));
    check("t5_rdata", 64'(rd), 64'hCAFE_F00D);
    tick();
    idle_masters();
    @(negedge clk);
    check("t5_err_flag", 64'(err_flag), 64'd0);

    // 6: reset while BUSY abandons the transaction; re-arbitration favours M0 again
    slave_lat = 1;
    tick();
    drive_m(0, 1'b1, 1'b0, 32'h0000_0060, 32'h0, 4'h0);
    wait_ready(20, who, rd);
    check("t6_setup_who", 64'(who), 64'd0);
    tick();
    slave_lat = 0;
    drive_m(0, 1'b1, 1'b0, 32'h0000_0064, 32'h0, 4'h0);
    drive_m(1, 1'b1, 1'b0, 32'h0000_0068, 32'h0, 4'h0);
    tick();
    @(negedge clk);
    check("t6_pre_grant_addr", 64'(mem_if.addr), 64'h68);
    p0 = m0_pulses; p1 = m1_pulses;
    tick();
    resetn = 1'b0;
    @(negedge clk);
    check("t6_rst_ready", 64'({m1_if.ready, m0_if.ready}), 64'd0);
    tick();
    resetn = 1'b1;
    @(negedge clk);
    check("t6_mem_valid", 64'(mem_if.valid), 64'd0);
    check("t6_state", 64'(dbg_state), 64'(IDLE));
    tick();
    @(negedge clk);
    check("t6_regrant_valid", 64'(mem_if.valid), 64'd1);
    check("t6_regrant_addr", 64'(mem_if.addr), 64'h64);
    check("t6_no_pulse", 64'((m0_pulses - p0) + (m1_pulses - p1)), 64'd0);
    do_reset();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
